// File: rtl/dma_burst_ctrl.sv
// Purpose: splits a DMA transfer into read/write burst pairs that never cross a 4 KB page or exceed MAX_BURST.
// Latency: CALC takes one cycle per burst; done pulses one cycle after the last write response (or the cycle after a zero-length start).
// Backpressure: rd/wr command valid holds with stable addr/len until ready; only one burst is in flight at a time.
module dma_burst_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_BYTES = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  total_beats,
    input  logic                  abort,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [7:0]            rd_cmd_len,
    input  logic                  rd_burst_done,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [7:0]            wr_cmd_len,
    input  logic                  wr_burst_done,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_RD_CMD, S_RD_WAIT, S_WR_CMD, S_WR_WAIT, S_FIN
    } state_t;

    localparam int BYTE_SHIFT = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [7:0]            len_q;
    logic                  aborted_q;

    logic [31:0]           src_bnd, dst_bnd, calc_beats;
    logic [8:0]            beats;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic [LEN_WIDTH-1:0]  rem_after;

    // Burst sizing: smallest of remaining beats, MAX_BURST and the beats left before each page edge.
    always_comb begin
        src_bnd    = (32'd4096 - {20'd0, src_q[11:0]}) >> BYTE_SHIFT;
        dst_bnd    = (32'd4096 - {20'd0, dst_q[11:0]}) >> BYTE_SHIFT;
        calc_beats = 32'(remaining_q);
        if (32'(MAX_BURST) < calc_beats) calc_beats = 32'(MAX_BURST);
        if (src_bnd < calc_beats)        calc_beats = src_bnd;
        if (dst_bnd < calc_beats)        calc_beats = dst_bnd;
        beats      = {1'b0, len_q} + 9'd1;
        addr_step  = ADDR_WIDTH'(beats) << BYTE_SHIFT;
        rem_after  = remaining_q - LEN_WIDTH'(beats);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and command handshake outputs.
    always_comb begin
        state_d      = state_q;
        rd_cmd_valid = 1'b0;
        wr_cmd_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (total_beats == '0) ? S_FIN : S_CALC;
            end
            S_CALC: begin
                state_d = abort ? S_FIN : S_RD_CMD;
            end
            S_RD_CMD: begin
                rd_cmd_valid = 1'b1;
                if (rd_cmd_ready) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_burst_done) state_d = S_WR_CMD;
            end
            S_WR_CMD: begin
                wr_cmd_valid = 1'b1;
                if (wr_cmd_ready) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (wr_burst_done) state_d = (rem_after == '0 || abort) ? S_FIN : S_CALC;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transfer context: captured on start, burst length latched in CALC, advanced on each write response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            aborted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q       <= src_addr & ALIGN_MASK;
                        dst_q       <= dst_addr & ALIGN_MASK;
                        remaining_q <= total_beats;
                        aborted_q   <= 1'b0;
                    end
                end
                S_CALC: begin
                    len_q <= 8'(calc_beats - 32'd1);
                    if (abort) aborted_q <= 1'b1;
                end
                S_WR_WAIT: begin
                    if (wr_burst_done) begin
                        src_q       <= src_q + addr_step;
                        dst_q       <= dst_q + addr_step;
                        remaining_q <= rem_after;
                        if (abort) aborted_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_cmd_addr = src_q;
    assign rd_cmd_len  = len_q;
    assign wr_cmd_addr = dst_q;
    assign wr_cmd_len  = len_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Purpose: self-checking bench for dma_burst_ctrl: directed table, hand sequences, randomized transfers vs a burst-list model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench drives random ready stalls and random completion delays.
module tb_dma_burst_ctrl;

    localparam int DB = 4;
    localparam int MB = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] total_beats;
    logic        abort;
    logic        rd_cmd_valid, rd_cmd_ready, rd_burst_done;
    logic [31:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic        wr_cmd_valid, wr_cmd_ready, wr_burst_done;
    logic [31:0] wr_cmd_addr;
    logic [7:0]  wr_cmd_len;
    logic        busy, done, aborted;

    dma_burst_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .total_beats(total_beats),
        .abort(abort),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_burst_done(rd_burst_done),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_burst_done(wr_burst_done),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] wa;
        logic [7:0]  len;
    } burst_t;

    // abort_k: -2 never, -1 held from start, k>=0 raised at read handshake of burst k
    typedef struct {
        logic [31:0] src, dst;
        int          total, abort_k, nb;
        logic [31:0] ra0, wa0;
        logic [7:0]  l0;
        logic [31:0] ra1, wa1;
        logic [7:0]  l1;
        logic        ab;
    } vec_t;

    burst_t exp_q[$];
    logic   exp_ab;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: chop the transfer into page-safe bursts with plain arithmetic, then apply the abort cut.
    task automatic model(input logic [31:0] src, input logic [31:0] dst, input int total, input int abort_k);
        logic [31:0] s, d;
        int rem, b, bs, bd;
        exp_q.delete();
        exp_ab = 1'b0;
        s   = src & ~32'(DB - 1);
        d   = dst & ~32'(DB - 1);
        rem = total;
        while (rem > 0) begin
            bs = (4096 - int'(s % 4096)) / DB;
            bd = (4096 - int'(d % 4096)) / DB;
            b  = rem;
            if (b > MB) b = MB;
            if (b > bs) b = bs;
            if (b > bd) b = bd;
            exp_q.push_back('{ra: s, wa: d, len: 8'(b - 1)});
            s   = s + 32'(b * DB);
            d   = d + 32'(b * DB);
            rem = rem - b;
        end
        if (abort_k == -1) begin
            if (total > 0) exp_ab = 1'b1;
            exp_q.delete();
        end else if (abort_k >= 0 && abort_k < exp_q.size()) begin
            while (exp_q.size() > abort_k + 1) void'(exp_q.pop_back());
            exp_ab = 1'b1;
        end
    endtask

    // Runs one transfer against exp_q/exp_ab, acting as read and write datapaths.
    task automatic run_transfer(input logic [31:0] src, input logic [31:0] dst, input int total,
                                input int abort_k, input bit rmode);
        int nrd = 0, nwr = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
        bit rd_pend = 0, wr_pend = 0, fin = 0;
        abort        = (abort_k == -1);
        src_addr     = src;
        dst_addr     = dst;
        total_beats  = 16'(total);
        start        = 1'b1;
        rd_cmd_ready = 1'b0;
        wr_cmd_ready = 1'b0;
        step();
        while (!fin && cyc < 3000) begin
            cyc++;
            start         = 1'b0;
            rd_burst_done = 1'b0;
            wr_burst_done = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin rd_burst_done = 1'b1; rd_pend = 0; end
                else rd_cnt--;
            end else if (rmode && $urandom_range(0, 9) == 0) rd_burst_done = 1'b1;
            if (wr_pend) begin
                if (wr_cnt == 0) begin wr_burst_done = 1'b1; wr_pend = 0; end
                else wr_cnt--;
            end else if (rmode && $urandom_range(0, 9) == 0) wr_burst_done = 1'b1;
            if (rmode && $urandom_range(0, 9) == 0) begin
                start       = 1'b1;
                src_addr    = $urandom;
                dst_addr    = $urandom;
                total_beats = 16'($urandom_range(0, 99));
            end
            chk("one_valid", 32'(rd_cmd_valid & wr_cmd_valid), 32'd0);
            rd_cmd_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_cmd_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rd_cmd_valid) begin
                if (nrd < exp_q.size()) begin
                    chk("rd_addr", rd_cmd_addr, exp_q[nrd].ra);
                    chk("rd_len", 32'(rd_cmd_len), 32'(exp_q[nrd].len));
                end else begin
                    n_checks++; n_errors++;
                    $display("FAIL rd_extra: read command %0d, only %0d expected", nrd, exp_q.size());
                end
                if (rd_cmd_ready) begin
                    rd_pend = 1;
                    rd_cnt  = rmode ? $urandom_range(0, 3) : 0;
                    if (abort_k == nrd) abort = 1'b1;
                    nrd++;
                end
            end
            if (wr_cmd_valid) begin
                if (nwr < exp_q.size()) begin
                    chk("wr_addr", wr_cmd_addr, exp_q[nwr].wa);
                    chk("wr_len", 32'(wr_cmd_len), 32'(exp_q[nwr].len));
                end else begin
                    n_checks++; n_errors++;
                    $display("FAIL wr_extra: write command %0d, only %0d expected", nwr, exp_q.size());
                end
                if (wr_cmd_ready) begin
                    wr_pend = 1;
                    wr_cnt  = rmode ? $urandom_range(0, 3) : 0;
                    nwr++;
                end
            end
            if (done) begin
                chk("aborted", 32'(aborted), 32'(exp_ab));
                chk("busy_fin", 32'(busy), 32'd1);
                chk("n_rd", 32'(nrd), 32'(exp_q.size()));
                chk("n_wr", 32'(nwr), 32'(exp_q.size()));
                if (total == 0) chk("zero_latency", 32'(cyc), 32'd1);
                fin = 1;
            end
            step();
        end
        if (!fin) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: no done after %0d cycles, required done", cyc);
        end
        start = 1'b0; abort = 1'b0;
        rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
        rd_burst_done = 1'b0; wr_burst_done = 1'b0;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("aborted_hold", 32'(aborted), 32'(exp_ab));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{src: 32'h0,         dst: 32'h1000_0000, total: 16, abort_k: -2, nb: 1,
                    ra0: 32'h0,         wa0: 32'h1000_0000, l0: 8'd15,
                    ra1: 32'h0,         wa1: 32'h0,         l1: 8'd0,  ab: 1'b0};
        vecs[1] = '{src: 32'h0000_0FF0, dst: 32'h2000_0000, total: 20, abort_k: -2, nb: 2,
                    ra0: 32'h0000_0FF0, wa0: 32'h2000_0000, l0: 8'd3,
                    ra1: 32'h0000_1000, wa1: 32'h2000_0010, l1: 8'd15, ab: 1'b0};
        vecs[2] = '{src: 32'h0,         dst: 32'h1000_0000, total: 0,  abort_k: -2, nb: 0,
                    ra0: 32'h0,         wa0: 32'h0,         l0: 8'd0,
                    ra1: 32'h0,         wa1: 32'h0,         l1: 8'd0,  ab: 1'b0};
        vecs[3] = '{src: 32'h0,         dst: 32'h1000_0000, total: 40, abort_k: 0,  nb: 1,
                    ra0: 32'h0,         wa0: 32'h1000_0000, l0: 8'd15,
                    ra1: 32'h0,         wa1: 32'h0,         l1: 8'd0,  ab: 1'b1};
        vecs[4] = '{src: 32'h0000_0003, dst: 32'h0000_1FFE, total: 2,  abort_k: -2, nb: 2,
                    ra0: 32'h0,         wa0: 32'h0000_1FFC, l0: 8'd0,
                    ra1: 32'h0000_0004, wa1: 32'h0000_2000, l1: 8'd0,  ab: 1'b0};
        vecs[5] = '{src: 32'h100,       dst: 32'h200,       total: 5,  abort_k: -1, nb: 0,
                    ra0: 32'h0,         wa0: 32'h0,         l0: 8'd0,
                    ra1: 32'h0,         wa1: 32'h0,         l1: 8'd0,  ab: 1'b1};

        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; total_beats = '0;
        rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
        rd_burst_done = 1'b0; wr_burst_done = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_rd_valid", 32'(rd_cmd_valid), 32'd0);
        chk("rst_wr_valid", 32'(wr_cmd_valid), 32'd0);
        chk("rst_rd_addr", rd_cmd_addr, 32'd0);
        chk("rst_wr_addr", wr_cmd_addr, 32'd0);
        chk("rst_len", 32'(rd_cmd_len | wr_cmd_len), 32'd0);
        resetn = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            exp_q.delete();
            if (vecs[i].nb > 0) exp_q.push_back('{ra: vecs[i].ra0, wa: vecs[i].wa0, len: vecs[i].l0});
            if (vecs[i].nb > 1) exp_q.push_back('{ra: vecs[i].ra1, wa: vecs[i].wa1, len: vecs[i].l1});
            exp_ab = vecs[i].ab;
            run_transfer(vecs[i].src, vecs[i].dst, vecs[i].total, vecs[i].abort_k, 1'b0);
        end

        // Read command stall with stable fields; stray start ignored
        src_addr = 32'h40; dst_addr = 32'h80; total_beats = 16'd8; start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(rd_cmd_valid), 32'd1);
            chk("stall_addr", rd_cmd_addr, 32'h40);
            chk("stall_len", 32'(rd_cmd_len), 32'd7);
            start = (i == 2);
            if (i == 2) begin src_addr = 32'h999; dst_addr = 32'h777; total_beats = 16'd3; end
            step();
        end
        start = 1'b0;
        chk("stall_still_valid", 32'(rd_cmd_valid), 32'd1);
        rd_cmd_ready = 1'b1;
        step();
        rd_cmd_ready = 1'b0;
        chk("stall_rd_dropped", 32'(rd_cmd_valid), 32'd0);
        rd_burst_done = 1'b1;
        step();
        rd_burst_done = 1'b0;
        chk("stall_wr_valid", 32'(wr_cmd_valid), 32'd1);
        chk("stall_wr_addr", wr_cmd_addr, 32'h80);
        chk("stall_wr_len", 32'(wr_cmd_len), 32'd7);
        wr_cmd_ready = 1'b1;
        step();
        wr_cmd_ready = 1'b0;
        wr_burst_done = 1'b1;
        step();
        wr_burst_done = 1'b0;
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_aborted", 32'(aborted), 32'd0);
        step();
        chk("stall_idle", 32'(busy), 32'd0);

        // Reset while waiting for a write response
        src_addr = 32'h0; dst_addr = 32'h1000; total_beats = 16'd8; start = 1'b1;
        rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rd_burst_done = 1'b1;
        step();
        rd_burst_done = 1'b0;
        step();
        chk("ww_busy", 32'(busy), 32'd1);
        chk("ww_wr_valid", 32'(wr_cmd_valid), 32'd0);
        rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
        resetn = 1'b0;
        step();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_valid", 32'(rd_cmd_valid), 32'd0);
        chk("mid_rst_wr_valid", 32'(wr_cmd_valid), 32'd0);
        chk("mid_rst_addr", wr_cmd_addr, 32'd0);
        resetn = 1'b1;
        model(32'h44, 32'h88, 1, -2);
        run_transfer(32'h44, 32'h88, 1, -2, 1'b0);

        // Randomized transfers against the burst-list model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] s, d;
            int tot, ak, r;
            s = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) s[11:0] = 12'($urandom_range(3840, 4095));
            if ($urandom_range(0, 1) == 1) d[11:0] = 12'($urandom_range(3840, 4095));
            tot = $urandom_range(0, 70);
            r   = $urandom_range(0, 9);
            ak  = (r == 0) ? -1 : (r <= 3) ? $urandom_range(0, 3) : -2;
            model(s, d, tot, ak);
            run_transfer(s, d, tot, ak, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
